wallace_mult_seq: RTL and testbench
===================================

WALLACE_MULT_SEQ -- requirements
Module: wallace_mult_seq

Interface
REQ-001 The block SHALL have parameter WIDTH, default 32, giving the operand width in bits; legal values are 4..64 and multiples of RADIX.
REQ-002 The block SHALL have parameter RADIX, default 4, giving the partial-product rows reduced per cycle; legal values are 1..WIDTH.
REQ-003 The block SHALL have port clk, input, 1 bit: the single clock; all state changes occur on its rising edge.
REQ-004 The block SHALL have port rst, input, 1 bit: the reset, which is synchronous and active-high.
REQ-005 The block SHALL have port in_valid, input, 1 bit: the operand pair is valid.
REQ-006 The block SHALL have port in_ready, output, 1 bit: the block can accept operands.
REQ-007 The block SHALL have port a, input, WIDTH bits: the multiplicand, unsigned.
REQ-008 The block SHALL have port b, input, WIDTH bits: the multiplier, unsigned.
REQ-009 The block SHALL have port out_valid, output, 1 bit: the product is valid.
REQ-010 The block SHALL have port out_ready, input, 1 bit: the consumer accepts the product.
REQ-011 The block SHALL have port product, output, 2*WIDTH bits: a*b.
REQ-012 The block SHALL have port busy, output, 1 bit: high in any state other than IDLE.

Function
REQ-013 The block SHALL implement FSM states IDLE, REDUCE, FINAL and DONE.
REQ-014 in_ready SHALL equal (state==IDLE); an operand pair is accepted on an edge where in_valid and in_ready are both high.
REQ-015 On acceptance, the block SHALL:
- load mcand = zero-extended a (2*WIDTH bits) and mplier = b;
- clear the sum and carry registers (2*WIDTH bits each) and the cycle counter;
- go to REDUCE.
REQ-016 Each REDUCE cycle SHALL run, for k = 0..RADIX-1, one 3:2 carry-save step on (sum, carry, pp_k):
- pp_k = mplier[k] ? (mcand << k) : 0;
- new sum = XOR of the three operands;
- new carry = majority of the three operands, shifted left 1, truncated to 2*WIDTH bits.
REQ-017 At the end of each REDUCE cycle, mcand SHALL shift left by RADIX, mplier SHALL shift right by RADIX, and the counter SHALL increment.
REQ-018 REDUCE SHALL go to FINAL after WIDTH/RADIX cycles.
REQ-019 FINAL SHALL register product = (sum + carry) mod 2^(2*WIDTH) in one cycle, then go to DONE.
REQ-020 In DONE, out_valid SHALL be 1 and product SHALL stay stable until an edge with out_ready=1, which returns the block to IDLE.
REQ-021 Latency SHALL be WIDTH/RADIX+1 edges from the accepting edge to out_valid rising; for defaults this is 9.
REQ-022 in_valid SHALL be ignored while busy; a new operand pair is accepted no earlier than the edge after the product handshake.
REQ-023 out_ready SHALL be ignored outside DONE.
REQ-024 product SHALL hold its last value in IDLE, REDUCE and FINAL; it changes only on the FINAL edge or on reset.

Reset
REQ-025 rst=1 at an edge SHALL force IDLE, zero sum/carry/mcand/mplier/counter, and set product=0 and out_valid=0.
REQ-026 After reset, in_ready SHALL be 1 and busy SHALL be 0.
REQ-027 Reset in any state, including mid-REDUCE or DONE with out_valid high, SHALL abort the operation with no product handshake.
REQ-028 rst SHALL take priority over in_valid and out_ready on the same edge.

Configuration
REQ-029 Macro WALLACE_MULT_SEQ_EARLY_TERM_EN SHALL control early termination.
REQ-030 With the macro defined:
- REDUCE SHALL go to FINAL at the end of any cycle after which the shifted mplier equals 0;
- on acceptance with b==0, the block SHALL go directly to FINAL;
- latency becomes (number of RADIX groups up to and including the highest set bit of b)+1, minimum 1.
REQ-031 With the macro undefined, latency SHALL be fixed at WIDTH/RADIX+1 for all operands, and products SHALL be identical in both builds.

Verification (WIDTH=32, RADIX=4)
REQ-032 Scenario: a=0xFFFFFFFF, b=0xFFFFFFFF -> product=0xFFFFFFFE00000001, out_valid 9 edges after acceptance, in both builds.
REQ-033 Scenario: a=3, b=5 -> product=15; latency 2 with the macro defined, 9 without.
REQ-034 Scenario: a=0x12345678, b=0x80000000 -> product=0x091A2B3C00000000, latency 9 in both builds.
REQ-035 Scenario: out_ready held low 5 cycles in DONE:
- product and out_valid stay stable, in_ready stays 0;
- on the out_ready=1 edge, the next state is IDLE with in_ready=1.
REQ-036 Scenario: rst asserted 4 edges after acceptance -> next cycle out_valid=0, product=0, in_ready=1, busy=0; a following a=7, b=6 -> product=42.
REQ-037 Scenario: in_valid=1 with new operands throughout busy -> they are ignored, and the first result is unchanged.

Source files
------------

// File: rtl/wallace_mult_seq.sv
//=============================================================================
// Module      : wallace_mult_seq
// Description : Sequential unsigned multiplier.  Reduces RADIX partial-product
//               rows per cycle into a carry-save sum/carry pair, then resolves
//               the pair with one carry-propagate add.
//               Optional macro: WALLACE_MULT_SEQ_EARLY_TERM_EN (early exit once
//               the remaining multiplier bits are all zero).
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module wallace_mult_seq #(
   parameter int WIDTH = 32,
   parameter int RADIX = 4
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 in_valid,
   output logic                 in_ready,
   input  logic [WIDTH-1:0]     a,
   input  logic [WIDTH-1:0]     b,
   output logic                 out_valid,
   input  logic                 out_ready,
   output logic [2*WIDTH-1:0]   product,
   output logic                 busy
);

   localparam int c_PW     = 2 * WIDTH;
   localparam int c_CYCLES = WIDTH / RADIX;
   localparam int c_CW     = $clog2(c_CYCLES + 1);

   localparam logic [1:0] c_IDLE   = 2'd0;
   localparam logic [1:0] c_REDUCE = 2'd1;
   localparam logic [1:0] c_FINAL  = 2'd2;
   localparam logic [1:0] c_DONE   = 2'd3;

`ifdef WALLACE_MULT_SEQ_EARLY_TERM_EN
   localparam logic c_EARLY = 1'b1;
`else
   localparam logic c_EARLY = 1'b0;
`endif

   logic [1:0]        r_state;
   logic [c_PW-1:0]   r_mcand;
   logic [WIDTH-1:0]  r_mplier;
   logic [c_PW-1:0]   r_sum;
   logic [c_PW-1:0]   r_carry;
   logic [c_CW-1:0]   r_cnt;
   logic [c_PW-1:0]   r_product;

   logic [c_PW-1:0]   w_sum   [0:RADIX];
   logic [c_PW-1:0]   w_carry [0:RADIX];
   logic [WIDTH-1:0]  w_mplier_nxt;
   logic              w_last;

   assign w_sum[0]   = r_sum;
   assign w_carry[0] = r_carry;

   // Chain of 3:2 compressors, one per partial-product row handled this cycle
   for (genvar k = 0; k < RADIX; k++) begin : g_csa
      logic [c_PW-1:0] w_pp;
      assign w_pp         = r_mplier[k] ? (r_mcand << k) : '0;
      assign w_sum[k+1]   = w_sum[k] ^ w_carry[k] ^ w_pp;
      assign w_carry[k+1] = ((w_sum[k] & w_carry[k]) |
                             (w_sum[k] & w_pp)       |
                             (w_carry[k] & w_pp)) << 1;
   end

   assign w_mplier_nxt = r_mplier >> RADIX;
   assign w_last       = (r_cnt == c_CW'(c_CYCLES - 1)) ||
                         (c_EARLY && (w_mplier_nxt == '0));

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state   <= c_IDLE;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_sum     <= '0;
         r_carry   <= '0;
         r_cnt     <= '0;
         r_product <= '0;
      end else begin
         case (r_state)
            c_IDLE: begin
               if (in_valid) begin
                  r_mcand  <= {{WIDTH{1'b0}}, a};
                  r_mplier <= b;
                  r_sum    <= '0;
                  r_carry  <= '0;
                  r_cnt    <= '0;
                  r_state  <= (c_EARLY && (b == '0)) ? c_FINAL : c_REDUCE;
               end
            end
            c_REDUCE: begin
               r_sum    <= w_sum[RADIX];
               r_carry  <= w_carry[RADIX];
               r_mcand  <= r_mcand << RADIX;
               r_mplier <= w_mplier_nxt;
               r_cnt    <= r_cnt + c_CW'(1);
               if (w_last) begin
                  r_state <= c_FINAL;
               end
            end
            c_FINAL: begin
               r_product <= r_sum + r_carry;
               r_state   <= c_DONE;
            end
            c_DONE: begin
               if (out_ready) begin
                  r_state <= c_IDLE;
               end
            end
            default: r_state <= c_IDLE;
         endcase
      end
   end

   assign in_ready  = (r_state == c_IDLE);
   assign out_valid = (r_state == c_DONE);
   assign busy      = (r_state != c_IDLE);
   assign product   = r_product;

endmodule

`default_nettype wire

// File: tb/tb_wallace_mult_seq.sv
//=============================================================================
// Module      : tb_wallace_mult_seq
// Description : Self-checking bench for wallace_mult_seq (WIDTH=32, RADIX=4),
//               reference product and latency computed arithmetically.
// Revision    : 1.0 - initial release
//=============================================================================
`default_nettype none

module tb_wallace_mult_seq;

   localparam int W = 32;
   localparam int R = 4;

   logic            clk = 1'b0;
   logic            rst = 1'b1;
   logic            in_valid = 1'b0;
   logic            in_ready;
   logic [W-1:0]    a = '0;
   logic [W-1:0]    b = '0;
   logic            out_valid;
   logic            out_ready = 1'b0;
   logic [2*W-1:0]  product;
   logic            busy;

   int n_cmp = 0;
   int n_err = 0;

   wallace_mult_seq #(.WIDTH(W), .RADIX(R)) dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a         (a),
      .b         (b),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product),
      .busy      (busy)
   );

   always #5 clk = ~clk;

   function automatic logic [2*W-1:0] ref_prod(input logic [W-1:0] x, input logic [W-1:0] y);
      logic [2*W-1:0] xx, yy;
      xx = {{W{1'b0}}, x};
      yy = {{W{1'b0}}, y};
      return xx * yy;
   endfunction

   function automatic int ref_lat(input logic [W-1:0] y);
`ifdef WALLACE_MULT_SEQ_EARLY_TERM_EN
      int hi = -1;
      for (int i = 0; i < W; i++) if (y[i]) hi = i;
      if (hi < 0) return 1;
      return hi / R + 2;
`else
      return W / R + 1;
`endif
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Present one operand pair in IDLE, return edges until out_valid (-1 on timeout)
   task automatic run_op(input logic [W-1:0] x, input logic [W-1:0] y,
                         output int lat, output logic [2*W-1:0] p);
      a = x; b = y; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      p = product;
   endtask

   task automatic handshake();
      out_ready = 1'b1;
      tick();
      out_ready = 1'b0;
   endtask

   task automatic test_reset();
      rst = 1'b1;
      tick(); tick();
      rst = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL reset_in_ready got=%b exp=1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL reset_busy got=%b exp=0", busy); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL reset_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (product !== '0) begin n_err++; $display("FAIL reset_product got=%h exp=0", product); end
   endtask

   task automatic test_directed();
      logic [W-1:0] xs [4] = '{32'hFFFFFFFF, 32'd3, 32'h12345678, 32'hDEADBEEF};
      logic [W-1:0] ys [4] = '{32'hFFFFFFFF, 32'd5, 32'h80000000, 32'd0};
      logic [2*W-1:0] exps [4] = '{64'hFFFFFFFE00000001, 64'd15, 64'h091A2B3C00000000, 64'd0};
      int lat;
      logic [2*W-1:0] p;
      for (int i = 0; i < 4; i++) begin
         run_op(xs[i], ys[i], lat, p);
         n_cmp++; if (p !== exps[i]) begin n_err++; $display("FAIL directed%0d_product got=%h exp=%h", i, p, exps[i]); end
         n_cmp++; if (lat !== ref_lat(ys[i])) begin n_err++; $display("FAIL directed%0d_latency got=%0d exp=%0d", i, lat, ref_lat(ys[i])); end
         handshake();
      end
   endtask

   task automatic test_random();
      logic [W-1:0] x, y;
      int lat;
      logic [2*W-1:0] p;
      for (int i = 0; i < 24; i++) begin
         x = $urandom();
         y = $urandom() >> $urandom_range(0, 31);
         run_op(x, y, lat, p);
         n_cmp++; if (p !== ref_prod(x, y)) begin n_err++; $display("FAIL random%0d_product a=%h b=%h got=%h exp=%h", i, x, y, p, ref_prod(x, y)); end
         n_cmp++; if (lat !== ref_lat(y)) begin n_err++; $display("FAIL random%0d_latency b=%h got=%0d exp=%0d", i, y, lat, ref_lat(y)); end
         handshake();
      end
   endtask

   task automatic test_backpressure();
      int lat;
      logic [2*W-1:0] p, exp_p;
      exp_p = ref_prod(32'hCAFEF00D, 32'h0BADC0DE);
      run_op(32'hCAFEF00D, 32'h0BADC0DE, lat, p);
      for (int i = 0; i < 5; i++) begin
         tick();
         n_cmp++; if (product !== exp_p) begin n_err++; $display("FAIL hold%0d_product got=%h exp=%h", i, product, exp_p); end
         n_cmp++; if (out_valid !== 1'b1) begin n_err++; $display("FAIL hold%0d_out_valid got=%b exp=1", i, out_valid); end
         n_cmp++; if (in_ready !== 1'b0) begin n_err++; $display("FAIL hold%0d_in_ready got=%b exp=0", i, in_ready); end
      end
      handshake();
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL release_in_ready got=%b exp=1", in_ready); end
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL release_out_valid got=%b exp=0", out_valid); end
   endtask

   task automatic test_reset_abort();
      int lat;
      logic [2*W-1:0] p;
      a = 32'h11111111; b = 32'hFFFFFFFF; in_valid = 1'b1;
      tick();
      in_valid = 1'b0;
      tick(); tick(); tick();
      rst = 1'b1; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL abort_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (product !== '0) begin n_err++; $display("FAIL abort_product got=%h exp=0", product); end
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL abort_in_ready got=%b exp=1", in_ready); end
      n_cmp++; if (busy !== 1'b0) begin n_err++; $display("FAIL abort_busy got=%b exp=0", busy); end
      run_op(32'd7, 32'd6, lat, p);
      n_cmp++; if (p !== 64'd42) begin n_err++; $display("FAIL abort_next_product got=%0d exp=42", p); end
      // Reset while the result is being presented
      rst = 1'b1;
      tick();
      rst = 1'b0;
      n_cmp++; if (out_valid !== 1'b0) begin n_err++; $display("FAIL done_abort_out_valid got=%b exp=0", out_valid); end
      n_cmp++; if (product !== '0) begin n_err++; $display("FAIL done_abort_product got=%h exp=0", product); end
   endtask

   task automatic test_ignore_busy();
      logic [W-1:0] x, y;
      int lat;
      x = 32'h89ABCDEF; y = 32'h00F0F0F1;
      a = x; b = y; in_valid = 1'b1; out_ready = 1'b1;
      tick();
      lat = -1;
      for (int i = 1; i <= 40; i++) begin
         a = $urandom(); b = $urandom();
         tick();
         if (out_valid) begin
            lat = i;
            break;
         end
      end
      in_valid = 1'b0;
      n_cmp++; if (product !== ref_prod(x, y)) begin n_err++; $display("FAIL busy_product got=%h exp=%h", product, ref_prod(x, y)); end
      n_cmp++; if (lat !== ref_lat(y)) begin n_err++; $display("FAIL busy_latency got=%0d exp=%0d", lat, ref_lat(y)); end
      tick();
      out_ready = 1'b0;
      n_cmp++; if (in_ready !== 1'b1) begin n_err++; $display("FAIL busy_return_in_ready got=%b exp=1", in_ready); end
   endtask

   initial begin
      test_reset();
      test_directed();
      test_random();
      test_backpressure();
      test_reset_abort();
      test_ignore_busy();
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end

endmodule

`default_nettype wire
